// File: rtl/serial_word_feeder_pkg.sv
// Shared definitions for the bit-serial feeder and the complementer stage downstream.
// Holds the feeder FSM state encoding, the gap-count width and a small helper.
// Contents: GAP_W (width of the gap-count parameter), state_t, max_int().
package serial_pkg;

    // Idle-gap counts fit in 4 bits (0..15).
    localparam int GAP_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        SHIFT = 2'd2,
        GAPW  = 2'd3
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/serial_word_feeder_if.sv
// Word-in / bit-out bundle for serial_word_feeder.
// master = word producer (drives in_valid/in_data, observes everything else).
// slave  = feeder (drives in_ready and the serial outputs).
interface serial_word_feeder_if #(parameter int W = 8);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         ser_x;
    logic         ser_clr;
    logic         ser_valid;
    logic         word_done;

    modport master (
        output in_valid, in_data,
        input  in_ready, ser_x, ser_clr, ser_valid, word_done
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, ser_x, ser_clr, ser_valid, word_done
    );
endinterface

// File: rtl/serial_word_feeder_bit_counter.sv
// Modulo-N up counter with synchronous clear (priority) and count enable.
// Latency: count updates on the edge after i_clr/i_en; no handshake.
// Ports: t_clock, r (async active-high), i_clr, i_en, o_count.
module bit_counter
    import serial_pkg::*;
#(
    parameter int N  = 8,
    parameter int CW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          t_clock,
    input  logic          r,
    input  logic          i_clr,
    input  logic          i_en,
    output logic [CW-1:0] o_count
);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge t_clock or posedge r) begin
        if (r) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= (r_count == LAST) ? '0 : r_count + CW'(1);
        end
    end

    assign o_count = r_count;
endmodule

// File: rtl/serial_word_feeder.sv
// Serializes W-bit words LSB first behind a one-cycle clear strobe, with GAP idle cycles after each word.
// Latency: ser_clr one cycle after the accepting edge, bit 0 the cycle after that; word_done on bit W-1.
// Backpressure: one-entry buffer behind the shift register; in_ready is registered and equals ~buf_full.
// Ports: t_clock, r (async active-high), bus (slave: in_valid/in_ready/in_data in, ser_x/ser_clr/ser_valid/word_done out).
module serial_word_feeder
    import serial_pkg::*;
#(
    parameter int W   = 8,
    parameter int GAP = 0
) (
    input  logic                 t_clock,
    input  logic                 r,
    serial_word_feeder_if.slave  bus
);
    // One counter serves both bit position and gap length.
    localparam int N  = max_int(W, GAP);
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] BIT_LAST    = CW'(W - 1);
    localparam logic [CW-1:0] BIT_PRELAST = CW'(W - 2);
    localparam logic [CW-1:0] GAP_LAST    = (GAP > 0) ? CW'(GAP - 1) : '0;

    state_t       r_state;
    logic [W-1:0] r_shift;
    logic [W-1:0] r_buf;
    logic         r_buf_full;
    logic         r_in_ready;
    logic         r_ser_x;
    logic         r_ser_clr;
    logic         r_ser_valid;
    logic         r_word_done;

    logic [CW-1:0] w_cnt;
    logic          w_hs;
    logic          w_shift_last;
    logic          w_gap_last;
    logic          w_decide;
    logic          w_take_buf;
    logic          w_hs_to_buf;
    logic          w_buf_full_nxt;
    logic          w_cnt_clr;
    logic          w_cnt_en;

    assign w_hs         = bus.in_valid & r_in_ready;
    assign w_shift_last = (r_state == SHIFT) && (w_cnt == BIT_LAST);
    assign w_gap_last   = (r_state == GAPW) && (w_cnt == GAP_LAST);
    // Next-word decision point: end of the last bit when there is no gap, else end of the gap.
    assign w_decide     = (w_shift_last && (GAP == 0)) || w_gap_last;
    // A word left in buf while idle (accepted during the final bit) is picked up from IDLE.
    assign w_take_buf   = r_buf_full && (w_decide || (r_state == IDLE));
    // Only an empty IDLE feeds the shift register directly; every other handshake lands in buf.
    assign w_hs_to_buf  = w_hs && (r_state != IDLE);
    // Simultaneous refill and drain keeps buf_full set.
    assign w_buf_full_nxt = w_hs_to_buf | (r_buf_full & ~w_take_buf);

    assign w_cnt_clr = (r_state == IDLE) || (r_state == CLEAR) || w_shift_last || w_gap_last;
    assign w_cnt_en  = (r_state == SHIFT) || (r_state == GAPW);

    bit_counter #(.N(N), .CW(CW)) u_bit_counter (
        .t_clock (t_clock),
        .r       (r),
        .i_clr   (w_cnt_clr),
        .i_en    (w_cnt_en),
        .o_count (w_cnt)
    );

    always_ff @(posedge t_clock or posedge r) begin
        if (r) begin
            r_state     <= IDLE;
            r_shift     <= '0;
            r_buf       <= '0;
            r_buf_full  <= 1'b0;
            r_in_ready  <= 1'b1;
            r_ser_x     <= 1'b0;
            r_ser_clr   <= 1'b0;
            r_ser_valid <= 1'b0;
            r_word_done <= 1'b0;
        end else begin
            r_buf_full  <= w_buf_full_nxt;
            r_in_ready  <= ~w_buf_full_nxt;
            if (w_hs_to_buf) begin
                r_buf <= bus.in_data;
            end
            // Strobes default low; set only on the edge entering their cycle.
            r_ser_clr   <= 1'b0;
            r_word_done <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (r_buf_full || w_hs) begin
                        r_shift     <= r_buf_full ? r_buf : bus.in_data;
                        r_state     <= CLEAR;
                        r_ser_clr   <= 1'b1;
                        r_ser_valid <= 1'b0;
                        r_ser_x     <= 1'b0;
                    end
                end

                CLEAR: begin
                    r_state     <= SHIFT;
                    r_ser_valid <= 1'b1;
                    r_ser_x     <= r_shift[0];
                end

                SHIFT: begin
                    if (w_shift_last) begin
                        r_ser_valid <= 1'b0;
                        r_ser_x     <= 1'b0;
                        if (GAP > 0) begin
                            r_state <= GAPW;
                        end else if (r_buf_full) begin
                            r_shift   <= r_buf;
                            r_state   <= CLEAR;
                            r_ser_clr <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        // Present the next bit; flag it as last when it is bit W-1.
                        r_shift     <= r_shift >> 1;
                        r_ser_x     <= r_shift[1];
                        r_word_done <= (w_cnt == BIT_PRELAST);
                    end
                end

                GAPW: begin
                    if (w_gap_last) begin
                        if (r_buf_full) begin
                            r_shift   <= r_buf;
                            r_state   <= CLEAR;
                            r_ser_clr <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.ser_x     = r_ser_x;
    assign bus.ser_clr   = r_ser_clr;
    assign bus.ser_valid = r_ser_valid;
    assign bus.word_done = r_word_done;
endmodule

// File: tb/tb_serial_word_feeder.sv
`timescale 1ns/1ps
module tb_serial_word_feeder;
    import serial_pkg::*;

    localparam int W = 8;

    logic t_clock = 1'b0;
    logic r;
    always #5 t_clock = ~t_clock;

    serial_word_feeder_if #(.W(W)) if0 ();
    serial_word_feeder_if #(.W(W)) if2 ();

    serial_word_feeder #(.W(W), .GAP(0)) dut0 (.t_clock(t_clock), .r(r), .bus(if0.slave));
    serial_word_feeder #(.W(W), .GAP(2)) dut2 (.t_clock(t_clock), .r(r), .bus(if2.slave));

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    // ---------------- scoreboard on dut0 ----------------
    logic [W-1:0] sb_q[$];

    always @(negedge t_clock) begin
        if (!r && if0.in_valid && if0.in_ready) sb_q.push_back(if0.in_data);
    end

    int           nb = 0;
    logic         seen_one = 1'b0;
    logic [W-1:0] fr_word = '0;
    logic [W-1:0] fr_comp = '0;
    logic [W-1:0] last_comp = '0;
    logic [W-1:0] sb_exp;
    logic [W-1:0] sb_exp_c;
    int           frames_done = 0;

    // Frame capture plus reference bit-serial two's complementer.
    always @(negedge t_clock) begin
        if (r) begin
            nb = 0;
            seen_one = 1'b0;
        end else begin
            if (if0.ser_clr) begin
                nb = 0;
                seen_one = 1'b0;
                fr_word = '0;
                fr_comp = '0;
            end
            if (if0.word_done) chk("done_with_valid", if0.ser_valid, 1);
            if (if0.ser_valid) begin
                if (nb < W) begin
                    fr_word[nb] = if0.ser_x;
                    fr_comp[nb] = seen_one ? ~if0.ser_x : if0.ser_x;
                end
                seen_one = seen_one | if0.ser_x;
                nb++;
                if (if0.word_done) begin
                    chk("frame_bits", nb, W);
                    if (sb_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL sb_unexpected: frame %0h received, none expected", fr_word);
                    end else begin
                        sb_exp   = sb_q.pop_front();
                        sb_exp_c = ~sb_exp + 1'b1;
                        chk("sb_word", fr_word, sb_exp);
                        chk("sb_comp", fr_comp, sb_exp_c);
                    end
                    last_comp = fr_comp;
                    frames_done++;
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic send(input int sel, input logic [W-1:0] d);
        int k;
        k = 0;
        if (sel == 0) begin if0.in_valid = 1'b1; if0.in_data = d; end
        else          begin if2.in_valid = 1'b1; if2.in_data = d; end
        @(negedge t_clock);
        while (((sel == 0) ? !if0.in_ready : !if2.in_ready) && k < 100) begin
            @(negedge t_clock);
            k++;
        end
        if (k >= 100) fail_now("send_handshake");
        @(posedge t_clock);
        #1;
        if (sel == 0) if0.in_valid = 1'b0; else if2.in_valid = 1'b0;
    endtask

    task automatic wait_frames(input int target);
        int k;
        k = 0;
        while (frames_done < target && k < 200) begin
            @(negedge t_clock);
            k++;
        end
        if (frames_done < target) fail_now("wait_frame");
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(posedge t_clock);
        #1;
    endtask

    typedef struct {
        logic [W-1:0] data;
        logic [W-1:0] comp;
    } vec_t;

    vec_t tbl[7];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] w0c, wa, wb;
        logic [2:0]   got[18];
        logic [2:0]   expv;
        logic         rdy_k2;
        int           fd, k, stall, gap_cnt, gap_bad, quiet;

        tbl[0] = '{8'h0C, 8'hF4};
        tbl[1] = '{8'h00, 8'h00};
        tbl[2] = '{8'h01, 8'hFF};
        tbl[3] = '{8'h80, 8'h80};
        tbl[4] = '{8'hFF, 8'h01};
        tbl[5] = '{8'hA5, 8'h5B};
        tbl[6] = '{8'h7F, 8'h81};

        r = 1'b1;
        if0.in_valid = 1'b0; if0.in_data = '0;
        if2.in_valid = 1'b0; if2.in_data = '0;

        // ---- reset state ----
        #12;
        chk("rst_ser_x",     if0.ser_x, 0);
        chk("rst_ser_clr",   if0.ser_clr, 0);
        chk("rst_ser_valid", if0.ser_valid, 0);
        chk("rst_word_done", if0.word_done, 0);
        chk("rst_in_ready",  if0.in_ready, 1);
        chk("rst_state",     dut0.r_state, IDLE);
        chk("rst_in_ready2", if2.in_ready, 1);
        #10 r = 1'b0;
        @(posedge t_clock);
        #1;

        // ---- table: single words, complementer result ----
        for (int i = 0; i < 7; i++) begin
            fd = frames_done;
            send(0, tbl[i].data);
            wait_frames(fd + 1);
            chk("tbl_comp", last_comp, tbl[i].comp);
            idle_cycles(3);
        end

        // ---- single word, cycle exact ----
        w0c = 8'h0C;
        send(0, w0c);                    // returns in cycle E+1
        for (int i = 1; i <= 10; i++) begin
            @(negedge t_clock);
            if (i == 1)      expv = 3'b100;
            else if (i <= 9) expv = {1'b0, 1'b1, w0c[i-2]};
            else             expv = 3'b000;
            chk("single_seq", {if0.ser_clr, if0.ser_valid, if0.ser_x}, expv);
            chk("single_done", if0.word_done, (i == 9) ? 1 : 0);
        end
        chk("single_idle", dut0.r_state, IDLE);
        idle_cycles(2);

        // ---- back-to-back ----
        wa = 8'h01; wb = 8'h80;
        rdy_k2 = 1'b1;
        fork
            begin
                send(0, wa);
                send(0, wb);
            end
            begin
                k = 0;
                @(negedge t_clock);
                while (!if0.ser_clr && k < 50) begin @(negedge t_clock); k++; end
                if (k >= 50) fail_now("b2b_start");
                for (int j = 0; j < 18; j++) begin
                    if (j > 0) @(negedge t_clock);
                    got[j] = {if0.ser_clr, if0.ser_valid, if0.ser_x};
                    if (j == 2) rdy_k2 = if0.in_ready;
                end
            end
        join
        for (int j = 0; j < 18; j++) begin
            if (j == 0 || j == 9) expv = 3'b100;
            else if (j < 9)       expv = {2'b01, wa[j-1]};
            else                  expv = {2'b01, wb[j-10]};
            chk("b2b_seq", got[j], expv);
        end
        chk("b2b_ready_low", rdy_k2, 0);
        idle_cycles(5);

        // ---- backpressure: in_valid held, data changing every cycle ----
        stall = 0;
        if0.in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if0.in_data = 8'h30 + 8'(i * 7);
            @(negedge t_clock);
            if (!if0.in_ready) stall++;
            @(posedge t_clock);
            #1;
        end
        if0.in_valid = 1'b0;
        chk("bp_stalled", (stall > 0), 1);
        k = 0;
        while (sb_q.size() != 0 && k < 100) begin @(negedge t_clock); k++; end
        chk("bp_drained", sb_q.size(), 0);
        idle_cycles(3);

        // ---- gap spacing on the GAP=2 instance ----
        gap_cnt = 0;
        gap_bad = 0;
        fork
            begin
                send(1, 8'hA5);
                send(1, 8'h3C);
            end
            begin
                k = 0;
                @(negedge t_clock);
                while (!if2.word_done && k < 60) begin @(negedge t_clock); k++; end
                if (k >= 60) fail_now("gap_first_done");
                @(negedge t_clock);
                while (!if2.ser_clr && gap_cnt < 20) begin
                    if (if2.ser_x || if2.ser_valid || if2.word_done) gap_bad++;
                    gap_cnt++;
                    @(negedge t_clock);
                end
            end
        join
        chk("gap_cycles", gap_cnt, 2);
        chk("gap_quiet", gap_bad, 0);
        idle_cycles(20);

        // ---- mid-word reset with buf full ----
        send(0, 8'hFF);
        send(0, 8'h55);                  // returns in bit-0 cycle
        @(posedge t_clock);
        @(posedge t_clock);
        @(posedge t_clock);
        #2;                              // inside bit-3 cycle
        chk("mrst_pre_valid", if0.ser_valid, 1);
        chk("mrst_pre_ready", if0.in_ready, 0);
        r = 1'b1;
        #1;
        sb_q.delete();
        chk("mrst_ser_x",     if0.ser_x, 0);
        chk("mrst_ser_clr",   if0.ser_clr, 0);
        chk("mrst_ser_valid", if0.ser_valid, 0);
        chk("mrst_word_done", if0.word_done, 0);
        @(posedge t_clock);
        @(posedge t_clock);
        #3 r = 1'b0;
        @(negedge t_clock);
        chk("mrst_ready", if0.in_ready, 1);
        quiet = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge t_clock);
            if (if0.ser_valid || if0.ser_clr) quiet++;
        end
        chk("mrst_nothing_sent", quiet, 0);

        chk("sb_empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_word_feeder.md
SERIAL_WORD_FEEDER -- requirements
Module: serial_word_feeder

Interface
REQ-001 The module SHALL have parameter W, default 8, giving the parallel word width in bits (W >= 2).
REQ-002 The module SHALL have parameter GAP, default 0, giving the number of idle cycles inserted after each word's last bit (0..15).
REQ-003 Port t_clock, input, 1 bit, the only clock; all state SHALL change on its rising edge.
REQ-004 Port r, input, 1 bit, SHALL be the asynchronous, active-high reset.
REQ-005 Port in_valid, input, 1 bit, SHALL mean that in_data holds a word offered for serialization.
REQ-006 Port in_ready, output, 1 bit, SHALL mean that the block accepts a word this cycle; a transfer occurs when in_valid and in_ready are both high at a rising edge.
REQ-007 Port in_data, input, W bits, SHALL be the parallel word, transmitted LSB first.
REQ-008 Port ser_x, output, 1 bit, SHALL be the serial data bit for the downstream bit-serial two's complementer.
REQ-009 Port ser_clr, output, 1 bit, SHALL be a one-cycle frame-start strobe that clears the downstream complementer's state.
REQ-010 Port ser_valid, output, 1 bit, SHALL be high exactly in the cycles where ser_x carries a word bit.
REQ-011 Port word_done, output, 1 bit, SHALL pulse during the cycle that carries bit W-1.

Function
REQ-012 The FSM SHALL have the states IDLE, CLEAR, SHIFT and GAPW.
- IDLE: nothing is being sent.
- CLEAR: ser_clr=1, ser_valid=0, ser_x=0.
- SHIFT: ser_valid=1, ser_x=shift[0].
- GAPW: all serial outputs are 0.
REQ-013 Storage SHALL be a W-bit shift register plus a one-entry holding buffer (buf, buf_full); in_ready SHALL equal ~buf_full and be registered, with no combinational path from in_valid.
REQ-014 A word accepted while in IDLE SHALL load directly into the shift register; the next cycle SHALL be CLEAR; the W cycles after that SHALL be SHIFT, sending bit 0 through bit W-1.
REQ-015 A word accepted in any other state SHALL load into buf.
REQ-016 The bit counter SHALL run 0..W-1 during SHIFT; at count W-1, word_done=1.
REQ-017 After the last SHIFT cycle, the FSM SHALL enter GAPW for GAP cycles if GAP>0; otherwise it SHALL take the next-word decision immediately.
REQ-018 Next-word decision: if buf_full, the FSM SHALL move buf into the shift register, clear buf_full and go to CLEAR; otherwise it SHALL go to IDLE.
REQ-019 If a handshake coincides with a buf-to-shift move, the new word SHALL enter buf and buf_full SHALL stay 1; no word may be lost or duplicated.
REQ-020 With GAP=0 and buf continuously refilled, the output SHALL be the repeating pattern of 1 CLEAR cycle followed by W SHIFT cycles, with no IDLE cycles.
REQ-021 in_data SHALL be sampled only at a handshake edge; later changes SHALL NOT affect a word in flight.
REQ-022 An all-zero word SHALL be transmitted normally, with no special case.

Reset
REQ-023 While r=1, the block SHALL asynchronously force: state=IDLE, counter=0, shift register=0, buf_full=0, in_ready=1 (asserting once r is released), ser_x=0, ser_clr=0, ser_valid=0, word_done=0.
REQ-024 A reset mid-word SHALL abandon that word and any buffered word; the first edge after release SHALL behave as a fresh IDLE.

Structure
REQ-025 The state enumeration and the GAP width constant SHALL live in the shared package serial_pkg, which the complementer stage also uses.
REQ-026 The bit and gap counter SHALL be a sub-module, bit_counter (modulo-N, with enable and synchronous clear).
REQ-027 The RTL SHALL be a single FSM with registered outputs.

Verification
REQ-028 The bench SHALL cover the following directed scenarios (W=8 unless stated):
- Single word: W=8, GAP=0, accept 8'h0C at edge E. Expected: ser_clr high for cycle E+1; ser_x = 0,0,1,1,0,0,0,0 over cycles E+2..E+9; word_done high at E+9; state IDLE at E+10. Feeding the complementer yields 8'hF4.
- Back-to-back: 8'h01 then 8'h80 offered continuously. Expected: clr, 1,0,0,0,0,0,0,0, clr, 0,0,0,0,0,0,0,1, with no idle cycle; in_ready low while buf is full.
- Gap spacing: GAP=2, two words. Expected: exactly 2 all-zero cycles between word_done and the second ser_clr.
- Backpressure: in_valid held high with changing in_data while in_ready=0. Expected: only the words present at handshake edges are sent, in order.
- Mid-word reset: assert r during bit 3 of 8'hFF with buf full. Expected: all outputs 0 immediately; in_ready=1 after release; neither word is sent.
- Zero word: 8'h00 sent. Expected: ser_valid high for 8 cycles with ser_x=0; the complementer yields 8'h00.
